// File: rtl/i2s_pcm_receiver_if.sv
// i2s_pcm_receiver_if: serial I2S pins, format controls and parallel PCM outputs.
// master drives the pins and controls, slave is the receiver.
interface i2s_pcm_receiver_if #(parameter int PCM_BIT_LENGTH = 32);
    logic bclk;
    logic lrck;
    logic data;
    logic [1:0] fmt;
    logic [5:0] wlen;
    logic [PCM_BIT_LENGTH-1:0] data_l;
    logic [PCM_BIT_LENGTH-1:0] data_r;
    logic valid;
    logic lock;
    logic frame_err;
    modport master (output bclk, lrck, data, fmt, wlen, input data_l, data_r, valid, lock, frame_err);
    modport slave (input bclk, lrck, data, fmt, wlen, output data_l, data_r, valid, lock, frame_err);
endinterface

// File: rtl/i2s_pcm_receiver.sv
// i2s_pcm_receiver: oversampled I2S/LJ/RJ receiver producing MSB-aligned stereo PCM words,
// with lock detection, framing error strobe and mute on bit-clock loss.
module i2s_pcm_receiver #(
    parameter int PCM_BIT_LENGTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic clk,
    input logic rst_n,
    i2s_pcm_receiver_if.slave bus
);
    localparam int W = PCM_BIT_LENGTH;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [6:0] W7 = 7'(PCM_BIT_LENGTH);

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, data_sync;
    logic bclk_hist, lr_prev;
    logic [6:0] cnt, prev_len, nbit;
    logic [2:0] eq_cnt;
    logic [TW-1:0] tcnt;
    logic [W-1:0] shreg, stage_l;
    logic rise, lr, din, boundary, fmt_lj, fmt_rj, fmt_i2s, ending_left;
    logic timed_out, shift_ok, len_ok, lock_next;
    logic [6:0] wl, nbit_next, pad;
    logic [2:0] eq_next;
    logic [W-1:0] sh_next, slot_val;

    always_comb begin
        rise = bclk_sync[SYNC_STAGES-1] & ~bclk_hist;
        lr = lrck_sync[SYNC_STAGES-1];
        din = data_sync[SYNC_STAGES-1];
        boundary = rise & (lr != lr_prev);
        fmt_lj = bus.fmt == 2'b01;
        fmt_rj = bus.fmt == 2'b10;
        fmt_i2s = !fmt_lj && !fmt_rj;
        ending_left = fmt_i2s ? !lr_prev : lr_prev;
        timed_out = tcnt == TW'(TIMEOUT_CYC);
        wl = {1'b0, bus.wlen} > W7 ? W7 : {1'b0, bus.wlen};
        shift_ok = nbit < W7;
        sh_next = shift_ok ? {shreg[W-2:0], din} : shreg;
        nbit_next = shift_ok ? nbit + 7'd1 : nbit;
        // in I2S the boundary bit still belongs to the slot that is ending
        pad = fmt_rj ? W7 - wl : fmt_i2s ? W7 - nbit_next : W7 - nbit;
        slot_val = (fmt_i2s ? sh_next : shreg) << pad;
        len_ok = cnt >= 7'd8 && cnt <= 7'd64 && cnt == prev_len && !(fmt_rj && cnt < wl);
        eq_next = !len_ok ? 3'd1 : eq_cnt == 3'd4 ? 3'd4 : eq_cnt + 3'd1;
        lock_next = len_ok && eq_next == 3'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
            bclk_hist <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], bus.lrck};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.data};
            bclk_hist <= bclk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev <= 1'b0;
            cnt <= '0;
            prev_len <= '0;
            nbit <= '0;
            eq_cnt <= '0;
            tcnt <= '0;
            shreg <= '0;
            stage_l <= '0;
            bus.data_l <= '0;
            bus.data_r <= '0;
            bus.valid <= 1'b0;
            bus.lock <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            bus.frame_err <= 1'b0;
            if (rise) begin
                tcnt <= '0;
                lr_prev <= lr;
                if (boundary) begin
                    cnt <= 7'd1;
                    prev_len <= cnt;
                    eq_cnt <= eq_next;
                    bus.lock <= lock_next;
                    bus.frame_err <= bus.lock && !len_ok;
                    shreg <= fmt_rj ? {shreg[W-2:0], din} : fmt_lj ? W'(din) : '0;
                    nbit <= fmt_lj ? 7'd1 : 7'd0;
                    if (ending_left)
                        stage_l <= slot_val;
                    else if (lock_next) begin
                        bus.data_l <= stage_l;
                        bus.data_r <= slot_val;
                        bus.valid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt == 7'd127 ? cnt : cnt + 7'd1;
                    shreg <= fmt_rj ? {shreg[W-2:0], din} : sh_next;
                    nbit <= nbit_next;
                end
            end else if (timed_out) begin
                // clock lost: mute and force a fresh lock once BCLK returns
                cnt <= '0;
                eq_cnt <= '0;
                bus.lock <= 1'b0;
                bus.data_l <= '0;
                bus.data_r <= '0;
            end else
                tcnt <= tcnt + TW'(1);
        end
    end
endmodule

// File: tb/tb_i2s_pcm_receiver.sv
// tb_i2s_pcm_receiver: randomized I2S/LJ/RJ streams checked against an arithmetic model
// of the expected MSB-aligned samples, lock timing, framing errors and timeout muting.
module tb_i2s_pcm_receiver;
    localparam int W = 32;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    i2s_pcm_receiver_if #(.PCM_BIT_LENGTH(W)) bus ();
    i2s_pcm_receiver #(.PCM_BIT_LENGTH(W), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    int wl_i = 32;
    logic [1:0] cur_fmt = 2'b00;
    logic prev_bit = 1'b0;
    logic [W-1:0] exp_l[$];
    logic [W-1:0] exp_r[$];
    logic [W-1:0] last_l, last_r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int n);
        return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic left_lvl();
        return cur_fmt == 2'b01 || cur_fmt == 2'b10;
    endfunction

    // expected PCM word: top W bits of the slot, or the low wlen bits for right-justified
    function automatic logic [W-1:0] ref_pcm(input logic [63:0] s, input int len);
        if (cur_fmt == 2'b10) return W'((s & mask(wl_i)) << (W - wl_i));
        return len >= W ? W'(s >> (len - W)) : W'(s << (W - len));
    endfunction

    always @(negedge clk) begin
        if (bus.frame_err) fe_seen++;
        if (bus.valid) begin
            check("valid_with_frame_err", bus.frame_err, 0);
            check("valid_expected", exp_l.size() > 0, 1);
            if (exp_l.size() > 0) begin
                check("data_l", bus.data_l, exp_l.pop_front());
                check("data_r", bus.data_r, exp_r.pop_front());
            end
        end
    end

    task automatic tx_bit(input logic lr, input logic d);
        @(negedge clk);
        bus.bclk = 1'b0;
        bus.lrck = lr;
        bus.data = (cur_fmt == 2'b00 || cur_fmt == 2'b11) ? prev_bit : d;
        prev_bit = d;
        repeat (3) @(negedge clk);
        bus.bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_slot(input logic lr, input logic [63:0] s, input int len);
        for (int i = len - 1; i >= 0; i--) tx_bit(lr, s[i]);
    endtask

    task automatic stream(input int len, input int n, input logic fixed,
                          input logic [63:0] sl, input logic [63:0] sr,
                          input logic [W-1:0] el, input logic [W-1:0] er);
        for (int k = 1; k <= n; k++) begin
            logic [63:0] a, b;
            a = fixed ? sl : {$urandom, $urandom} & mask(len);
            b = fixed ? sr : {$urandom, $urandom} & mask(len);
            tx_slot(left_lvl(), a, len);
            tx_slot(!left_lvl(), b, len);
            if (k == 1) check("lock_after_frame1", bus.lock, 0);
            if (k >= 2) begin
                last_l = fixed ? el : ref_pcm(a, len);
                last_r = fixed ? er : ref_pcm(b, len);
                exp_l.push_back(last_l);
                exp_r.push_back(last_r);
            end
        end
    endtask

    task automatic close_and_settle();
        tx_slot(left_lvl(), 64'd0, 2);
        repeat (20) @(negedge clk);
        check("queue_drained", exp_l.size(), 0);
        check("lock_held", bus.lock, 1);
        check("frame_err_count", fe_seen, fe_exp);
        check("hold_l", bus.data_l, last_l);
        check("hold_r", bus.data_r, last_r);
    endtask

    task automatic reset_to(input logic [1:0] f, input int wl);
        #2 rst_n = 1'b0;
        #1;
        check("rst_lock", bus.lock, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_data_l", bus.data_l, 0);
        check("rst_data_r", bus.data_r, 0);
        cur_fmt = f;
        wl_i = wl;
        bus.fmt = f;
        bus.wlen = 6'(wl);
        bus.bclk = 1'b0;
        prev_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.bclk = 1'b0;
        bus.lrck = 1'b0;
        bus.data = 1'b0;
        bus.fmt = 2'b00;
        bus.wlen = 6'd32;
        reset_to(2'b00, 32);
        stream(32, 4, 1'b1, 64'h12345678, 64'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0);
        close_and_settle();
        reset_to(2'b00, 32);
        stream(32, 3, 1'b0, 0, 0, 0, 0);
        close_and_settle();
        reset_to(2'b01, 32);
        stream(32, 3, 1'b1, 64'hABCDEF00, 64'h80000100, 32'hABCDEF00, 32'h80000100);
        close_and_settle();
        reset_to(2'b01, 32);
        stream(16, 3, 1'b1, 64'h7FFF, 64'h8000, 32'h7FFF0000, 32'h80000000);
        close_and_settle();
        reset_to(2'b10, 16);
        stream(32, 3, 1'b1, 64'hDEAD8001, 64'h12340002, 32'h80010000, 32'h00020000);
        close_and_settle();
        reset_to(2'b00, 32);
        stream(32, 3, 1'b0, 0, 0, 0, 0);
        fe_exp++;
        stream(24, 3, 1'b0, 0, 0, 0, 0);
        close_and_settle();
        repeat (TO + 20) @(negedge clk);
        check("timeout_lock", bus.lock, 0);
        check("timeout_data_l", bus.data_l, 0);
        check("timeout_data_r", bus.data_r, 0);
        check("timeout_frame_err", fe_seen, fe_exp);
        stream(24, 3, 1'b0, 0, 0, 0, 0);
        close_and_settle();
        for (int t = 0; t < 5; t++) begin
            logic [1:0] f;
            int wl, len;
            f = 2'($urandom_range(0, 3));
            wl = $urandom_range(16, 32);
            len = (f == 2'b10) ? $urandom_range(wl, 64) : $urandom_range(8, 64);
            reset_to(f, wl);
            stream(len, $urandom_range(3, 4), 1'b0, 0, 0, 0, 0);
            close_and_settle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
